shift_rows_pipe: RTL



---
 rtl/shift_rows_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/shift_rows_pipe.sv
// Pipelined AES ShiftRows (forward or inverse per block) for NB = 4/6/8 columns,
// followed by a two-entry elastic buffer with registered ready.
module shift_rows_pipe #(
    parameter int NB = 4,
    parameter int W  = 32 * NB
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Valid,
    output logic         o_Ready,
    input  logic         i_Mode,
    input  logic [W-1:0] i_Din,
    output logic         o_Valid,
    input  logic         i_Ready,
    output logic [W-1:0] o_Dout,
    output logic         o_Mode,
    output logic [1:0]   o_Occupancy
);
    localparam int NBYTES = 4 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (W != 32 * NB) begin : g_bad_w
        $error("shift_rows_pipe: W must equal 32*NB");
    end

    function automatic int row_off(input int r);
        case (r)
            0:       return 0;
            1:       return 1;
            2:       return (NB == 8) ? 3 : 2;
            default: return (NB == 8) ? 4 : 3;
        endcase
    endfunction

    // Source indices are elaboration constants, so both permutations are wiring only.
    logic [W-1:0] fwd_perm, inv_perm, perm_data;
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int DST = r + 4 * c;
            localparam int SF  = r + 4 * ((c + row_off(r)) % NB);
            localparam int SI  = r + 4 * ((c + NB - row_off(r)) % NB);
            assign fwd_perm[8*(NBYTES-1-DST) +: 8] = i_Din[8*(NBYTES-1-SF) +: 8];
            assign inv_perm[8*(NBYTES-1-DST) +: 8] = i_Din[8*(NBYTES-1-SI) +: 8];
        end
    end
    assign perm_data = i_Mode ? inv_perm : fwd_perm;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e         occ_q, occ_d;
    logic [W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic         m_mode_q, m_mode_d, s_mode_q, s_mode_d;
    logic         accept, drain;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            occ_q    <= OCC_EMPTY;
            m_data_q <= '0;
            m_mode_q <= 1'b0;
            s_data_q <= '0;
            s_mode_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            m_data_q <= m_data_d;
            m_mode_q <= m_mode_d;
            s_data_q <= s_data_d;
            s_mode_q <= s_mode_d;
        end
    end

    always_comb begin
        occ_d    = occ_q;
        m_data_d = m_data_q;
        m_mode_d = m_mode_q;
        s_data_d = s_data_q;
        s_mode_d = s_mode_q;
        accept   = i_Valid & o_Ready;
        drain    = o_Valid & i_Ready;
        case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    m_data_d = perm_data;
                    m_mode_d = i_Mode;
                    occ_d    = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && drain) begin
                    m_data_d = perm_data;
                    m_mode_d = i_Mode;
                end else if (accept) begin
                    s_data_d = perm_data;
                    s_mode_d = i_Mode;
                    occ_d    = OCC_FULL;
                end else if (drain) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (drain) begin
                    m_data_d = s_data_q;
                    m_mode_d = s_mode_q;
                    occ_d    = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_comb begin
        o_Valid     = (occ_q != OCC_EMPTY);
        o_Ready     = (occ_q != OCC_FULL);
        o_Occupancy = occ_q;
        o_Dout      = m_data_q;
        o_Mode      = m_mode_q;
    end
endmodule
